// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state, opcode and control-code encodings shared by the main control slice
package mc_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_ADDI_EX  = 4'd11;
  localparam logic [3:0] S_ADDI_WB  = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] AC_ADD   = 2'b00;
  localparam logic [1:0] AC_SUB   = 2'b01;
  localparam logic [1:0] AC_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ac;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that hold a memory strobe until mem_ready or timeout
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// rtl/mc_main_control_if.sv - opcode/handshake inputs and datapath strobes of the main control
interface mc_main_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] AC;
  logic [1:0] PCSource;
  logic       mem_err;
  logic       illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, AC, PCSource, mem_err, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, AC, PCSource, mem_err, illegal_op
  );
endinterface

// File: rtl/mc_mem_timer.sv
// rtl/mc_mem_timer.sv - memory wait counter; expire marks the last allowed cycle without mem_ready
module mc_mem_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = en && (count == LAST);
endmodule

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multicycle MIPS main control FSM; MC_ILLEGAL_TRAP_EN traps illegal opcodes into HALT
module mc_main_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input logic               clk,
  input logic               rst,
  mc_main_control_if.master bus
);
  logic [3:0] state;
  logic [3:0] state_next;
  logic       in_wait;
  logic       wait_en;
  logic       wait_clr;
  logic       expire;
  logic       mem_err_q;
  ctrl_t      ctrl;

  assign in_wait  = is_wait_state(state);
  assign wait_en  = in_wait && !bus.mem_ready;
  assign wait_clr = !in_wait || bus.mem_ready || expire;

  mc_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (wait_clr),
    .en    (wait_en),
    .expire(expire)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     state_next = S_FETCH;
      S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
                  else if (expire)   state_next = S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:      state_next = S_EXEC_R;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ:        state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
          OP_ADDI:       state_next = S_ADDI_EX;
`ifdef MC_ILLEGAL_TRAP_EN
          default:       state_next = S_HALT;
`else
          default:       state_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: state_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_next = S_MEM_WB;
                  else if (expire)   state_next = S_FETCH;
      S_MEM_WB:   state_next = S_FETCH;
      S_MEM_WR:   if (bus.mem_ready || expire) state_next = S_FETCH;
      S_EXEC_R:   state_next = S_R_WB;
      S_R_WB:     state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_ADDI_EX:  state_next = S_ADDI_WB;
      S_ADDI_WB:  state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      mem_err_q <= expire;
    end
  end

  // Moore decode; IR/PC load in FETCH is the one strobe gated by mem_ready
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ac        = AC_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE:   ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.ac        = AC_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.ac            = AC_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB:  ctrl.reg_write = 1'b1;
      default:    ctrl = '0;
    endcase
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.AC          = ctrl.ac;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.mem_err     = mem_err_q;

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state == S_DECODE && state_next == S_HALT) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal_op = illegal_q;
`else
  assign bus.illegal_op = 1'b0;
`endif
endmodule
